// File: rtl/obs_l4_pkg.sv
// obs_l4_pkg: widths, FSM states and product index shared by the OBS L4 multiply sequencer.
package obs_l4_pkg;
   localparam int N_OP   = 104;
   localparam int N_HALF = 52;
   localparam int N_PART = 103;
   localparam int N_PROD = 207;
   typedef enum logic [1:0] {IDLE, ISSUE, COMBINE, DONE} state_t;
   typedef logic [1:0] idx_t;
endpackage

// File: rtl/obs_l4_mult_sequencer_overlap.sv
// overlap_module_103bit: interleaves even/odd partial products (polynomials in x^2) into the 207-bit product.
module overlap_module_103bit
   import obs_l4_pkg::*;
(
   input  logic [N_PART-1:0] in1,
   input  logic [N_PART-1:0] in2,
   input  logic [N_PART-1:0] in3,
   input  logic [N_PART-1:0] in4,
   output logic [N_PROD-1:0] prod
);
   // in1 lands on even bits, in2/in3 on odd bits, in4 on even bits shifted by x^2
   assign prod[0] = in1[0];
   for (genvar j = 0; j < N_PART; j++) begin : g_bit
      assign prod[2*j+1] = in2[j] ^ in3[j];
      if (j < N_PART-1) begin : g_mid
         assign prod[2*j+2] = in4[j] ^ in1[j+1];
      end else begin : g_top
         assign prod[2*j+2] = in4[j];
      end
   end
endmodule

// File: rtl/obs_l4_mult_sequencer.sv
// obs_l4_mult_sequencer: time-shares one 52x52 GF(2) multiplier to build a 104x104 OBS product.
// Define OBS_SEQ_KARATSUBA_EN for the three-multiply Karatsuba schedule.
module obs_l4_mult_sequencer
   import obs_l4_pkg::*;
#(
   parameter int N = N_OP
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_a,
   input  logic [N-1:0]   in_b,
   output logic           mul_req,
   output logic [N/2-1:0] mul_a,
   output logic [N/2-1:0] mul_b,
   input  logic           mul_ack,
   input  logic [N-2:0]   mul_p,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-2:0] out_p,
   output logic           busy
);
   state_t state, state_d;
   idx_t idx, cap, last;
   logic [N/2-1:0] ae, ao, be, bo, sa_e, sa_o, sb_e, sb_o, op_a, op_b;
   logic [N-2:0] p [4];
   logic [N-2:0] mid, low;
   logic [2*N-2:0] ov;
   always_comb begin
      sa_e = '0;
      sa_o = '0;
      sb_e = '0;
      sb_o = '0;
      for (int i = 0; i < N/2; i++) begin
         sa_e[i] = in_a[2*i];
         sa_o[i] = in_a[2*i+1];
         sb_e[i] = in_b[2*i];
         sb_o[i] = in_b[2*i+1];
      end
   end
`ifdef OBS_SEQ_KARATSUBA_EN
   // p[0]=ae*be, p[3]=ao*bo, p[1] holds the middle product (ae^ao)*(be^bo)
   assign last = 2'd2;
   assign op_a = (idx == 2'd2) ? ae ^ ao : idx[0] ? ao : ae;
   assign op_b = (idx == 2'd2) ? be ^ bo : idx[0] ? bo : be;
   assign cap  = (idx == 2'd1) ? 2'd3 : (idx == 2'd2) ? 2'd1 : 2'd0;
   assign mid  = p[1] ^ p[0] ^ p[3];
   assign low  = '0;
`else
   assign last = 2'd3;
   assign op_a = idx[1] ? ao : ae;
   assign op_b = idx[0] ? bo : be;
   assign cap  = idx;
   assign mid  = p[1];
   assign low  = p[2];
`endif
   overlap_module_103bit u_overlap (
      .in1  (p[0]),
      .in2  (mid),
      .in3  (low),
      .in4  (p[3]),
      .prod (ov)
   );
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = in_valid ? ISSUE : IDLE;
         ISSUE:   state_d = (mul_ack && idx == last) ? COMBINE : ISSUE;
         COMBINE: state_d = DONE;
         DONE:    state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   assign in_ready  = state == IDLE;
   assign busy      = state != IDLE;
   assign out_valid = state == DONE;
   assign mul_req   = state == ISSUE;
   assign mul_a     = mul_req ? op_a : '0;
   assign mul_b     = mul_req ? op_b : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         ae    <= '0;
         ao    <= '0;
         be    <= '0;
         bo    <= '0;
         p     <= '{default: '0};
         out_p <= '0;
      end else begin
         state <= state_d;
         if (state == IDLE && in_valid) begin
            ae  <= sa_e;
            ao  <= sa_o;
            be  <= sb_e;
            bo  <= sb_o;
            idx <= '0;
         end
         if (state == ISSUE && mul_ack) begin
            p[cap] <= mul_p;
            idx    <= idx + 2'd1;
         end
         if (state == COMBINE) out_p <= ov;
      end
   end
endmodule

// File: tb/tb_obs_l4_mult_sequencer.sv
// tb_obs_l4_mult_sequencer: directed and random checks of the OBS L4 sequencer against a bit-serial GF(2) multiply.
module tb_obs_l4_mult_sequencer;
`ifdef OBS_SEQ_KARATSUBA_EN
   localparam int NOPS = 3;
`else
   localparam int NOPS = 4;
`endif
   localparam int LAT0 = NOPS + 2;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, force_ack = 0;
   logic in_ready, mul_req, mul_ack, out_valid, busy;
   logic [103:0] in_a = '0, in_b = '0;
   logic [51:0] mul_a, mul_b;
   logic [102:0] mul_p;
   logic [206:0] out_p;
   int n_chk = 0, n_ok = 0, ack_delay = 0, wait_cnt = 0, pairs = 0, unstable = 0;
   logic prev_wait = 0;
   logic [51:0] prev_a, prev_b;
   always #5 clk = ~clk;
   obs_l4_mult_sequencer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack), .mul_p(mul_p),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
   );
   function automatic logic [102:0] gf52(input logic [51:0] x, input logic [51:0] y);
      logic [102:0] r = '0;
      for (int i = 0; i < 52; i++) if (y[i]) r = r ^ ({51'b0, x} << i);
      return r;
   endfunction
   function automatic logic [206:0] gf104(input logic [103:0] x, input logic [103:0] y);
      logic [206:0] r = '0;
      for (int i = 0; i < 104; i++) if (y[i]) r = r ^ ({103'b0, x} << i);
      return r;
   endfunction
   assign mul_p   = gf52(mul_a, mul_b);
   assign mul_ack = force_ack | (mul_req && wait_cnt == ack_delay);
   always @(posedge clk) begin
      wait_cnt <= (mul_req && !mul_ack) ? wait_cnt + 1 : 0;
      if (mul_req && mul_ack) pairs <= pairs + 1;
      if (prev_wait && (!mul_req || mul_a != prev_a || mul_b != prev_b)) unstable <= unstable + 1;
      prev_wait <= mul_req && !mul_ack;
      prev_a <= mul_a;
      prev_b <= mul_b;
   end
   task automatic chk(input string tag, input logic [206:0] got, input logic [206:0] exp);
      n_chk++;
      if (got === exp) n_ok++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic run_op(input logic [103:0] a, input logic [103:0] b, output int lat);
      in_a = a;
      in_b = b;
      in_valid = 1;
      @(posedge clk);
      #1 in_valid = 0;
      lat = 1;
      while (!out_valid && lat < 300) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask
   task automatic finish_op();
      out_ready = 1;
      @(posedge clk);
      #1 out_ready = 0;
   endtask
   logic [103:0] va [5];
   logic [103:0] vb [5];
   logic [206:0] ve [5];
   logic [127:0] ra, rb;
   logic [206:0] held;
   int lat;
   initial begin
      va[0] = 104'd1; vb[0] = 104'd1; ve[0] = 207'd1;
      va[1] = 104'd2; vb[1] = 104'd2; ve[1] = 207'd4;
      va[2] = 104'd3; vb[2] = 104'd3; ve[2] = 207'd5;
      va[3] = 104'd1 << 103; vb[3] = 104'd1 << 103; ve[3] = 207'd1 << 206;
      va[4] = '1; vb[4] = '1; ve[4] = '0;
      for (int i = 0; i <= 206; i += 2) ve[4][i] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 207'(in_ready), 207'd1);
      chk("rst_mul_req", 207'(mul_req), 207'd0);
      chk("rst_mul_a", 207'(mul_a), 207'd0);
      chk("rst_mul_b", 207'(mul_b), 207'd0);
      chk("rst_out_valid", 207'(out_valid), 207'd0);
      chk("rst_out_p", out_p, 207'd0);
      chk("rst_busy", 207'(busy), 207'd0);
      rst = 0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) begin
         pairs = 0;
         run_op(va[k], vb[k], lat);
         chk($sformatf("dir%0d_p", k), out_p, ve[k]);
         chk($sformatf("dir%0d_lat", k), 207'(lat), 207'(LAT0));
         chk($sformatf("dir%0d_pairs", k), 207'(pairs), 207'(NOPS));
         finish_op();
         chk($sformatf("dir%0d_idle", k), 207'(in_ready), 207'd1);
      end
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      run_op(ra[103:0], rb[103:0], lat);
      held = gf104(ra[103:0], rb[103:0]);
      in_valid = 1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk("stall_p", out_p, held);
         chk("stall_in_ready", 207'(in_ready), 207'd0);
         chk("stall_valid", 207'(out_valid), 207'd1);
      end
      in_valid = 0;
      finish_op();
      chk("stall_release", 207'(busy), 207'd0);
      ack_delay = 3;
      for (int k = 0; k < 1000; k++) begin
         ra = {$urandom, $urandom, $urandom, $urandom};
         rb = {$urandom, $urandom, $urandom, $urandom};
         run_op(ra[103:0], rb[103:0], lat);
         chk("rand_p", out_p, gf104(ra[103:0], rb[103:0]));
         chk("rand_lat", 207'(lat), 207'(LAT0 + NOPS * 3));
         finish_op();
      end
      chk("hold_stable", 207'(unstable), 207'd0);
      ack_delay = 0;
      in_a = 104'd3;
      in_b = 104'd3;
      in_valid = 1;
      @(posedge clk);
      #1 in_valid = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      chk("abort_req", 207'(mul_req), 207'd0);
      chk("abort_valid", 207'(out_valid), 207'd0);
      chk("abort_idle", 207'(in_ready), 207'd1);
      force_ack = 1;
      @(posedge clk);
      #1 force_ack = 0;
      chk("spur_busy", 207'(busy), 207'd0);
      chk("spur_out_p", out_p, 207'd0);
      pairs = 0;
      run_op(104'd3, 104'd3, lat);
      chk("post_rst_p", out_p, 207'd5);
      chk("post_rst_lat", 207'(lat), 207'(LAT0));
      chk("post_rst_pairs", 207'(pairs), 207'(NOPS));
      finish_op();
      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end
endmodule

// File: doc/obs_l4_mult_sequencer.md
# obs_l4_mult_sequencer

Multi-cycle controller that computes a 104-bit GF(2) polynomial product by time-sharing one external 52x52-bit binary-polynomial multiplier across the OBS even/odd partial products. It splits each operand into even and odd coefficient halves, issues the partial products to the shared multiplier through a req/ack handshake, and holds the results in registers. It then interleaves the results with `overlap_module_103bit` into the 207-bit product. It sits between the L4 operand source and the 409-bit top-level recombination.

## Interface
Parameters:
- `N`, 104: operand width; half width `N/2` = 52; partial width `N-1` = 103; product width `2N-1` = 207.

Ports:
- `clk` input 1: single clock, all state on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands valid.
- `in_ready` output 1: block can accept operands.
- `in_a` input N: operand A; bit i is the coefficient of x^i.
- `in_b` input N: operand B.
- `mul_req` output 1: request to the shared multiplier.
- `mul_a` output N/2: multiplier operand A.
- `mul_b` output N/2: multiplier operand B.
- `mul_ack` input 1: multiplier result valid this cycle.
- `mul_p` input N-1: multiplier result.
- `out_valid` output 1: product valid.
- `out_ready` input 1: consumer accepts the product.
- `out_p` output 2N-1: product.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Operand split: ae[i] = a[2i] and ao[i] = a[2i+1]. be and bo are split the same way from B.
- FSM states: IDLE, ISSUE, COMBINE, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch ae, ao, be, bo; clear idx to 0; go to ISSUE.
- ISSUE:
  - `mul_req`=1, with `mul_a`/`mul_b` selected by idx:
    - idx 0: ae,be
    - idx 1: ae,bo
    - idx 2: ao,be
    - idx 3: ao,bo
  - When `mul_ack`=1: capture `mul_p` into P[idx] and increment idx.
  - After the capture at idx 3, go to COMBINE.
- COMBINE:
  - Register `out_p` = overlap(P0, P1, P2, P3). in1=P0, in2=P1, in3=P2, in4=P3.
  - Go to DONE.
- DONE:
  - `out_valid`=1; `out_p` is stable.
  - When `out_ready`=1, go to IDLE.
- `mul_a`, `mul_b` and `mul_req` change only on an ack or a state change. They stay constant while req is held.
- `mul_ack` while `mul_req`=0 is ignored.
- Reset values:
  - State IDLE, idx 0.
  - `in_ready`=1.
  - `mul_req`=0, `mul_a`=0, `mul_b`=0.
  - `out_valid`=0, `out_p`=0, `busy`=0.
  - P registers = 0.
- Reset in any state aborts the operation and discards partial results. No `mul_req` is issued in the cycle after reset.

## Timing
- Accept at cycle T. The first `mul_req` is at T+1.
- With `mul_ack` returned in the same cycle as req, products are issued at T+1..T+4, COMBINE is at T+5 and `out_valid` rises at T+6. Latency is 6 cycles.
- Each cycle of ack delay adds one cycle of latency.
- `in_ready` is low from T+1 until the cycle after the output handshake. Operations never overlap.
- `out_valid` is held for as long as `out_ready` is low.
- The output handshake and a new `in_valid` are never both taken in the same cycle. The new operands are accepted in the cycle after the return to IDLE.

## Configuration
- `OBS_SEQ_KARATSUBA_EN` defined: three multiplier operations are issued.
  - idx 0: ae·be → P0
  - idx 1: ao·bo → P3
  - idx 2: (ae^ao)·(be^bo) → Pm
  - COMBINE uses in2 = Pm^P0^P3 and in3 = 0.
  - Latency is 5 cycles with same-cycle ack.
- Not defined: the four-product schedule above.
- `out_p` is bit-identical in both builds.

## Structure
- Shared package `obs_l4_pkg` holds:
  - Width constants: N_OP=104, N_HALF=52, N_PART=103, N_PROD=207.
  - State enum type.
  - Product index type.
- One natural sub-module: an `overlap_module_103bit` instance, driven from the P registers, with its output registered in COMBINE.
- Even/odd split and operand mux are inline logic.

## Test plan
- a=1, b=1, ack same cycle → `out_p`=1; `out_valid` at T+6 (T+5 with `OBS_SEQ_KARATSUBA_EN`); exactly 4 (or 3) req/ack pairs.
- a=2, b=2 → `out_p`=4 (x²). a=3, b=3 → `out_p`=5 (1+x²; carries are dropped).
- a=b=2^103 → `out_p` = 2^206 (MSB only). a=b=all-ones → `out_p` has bits {0,2,…,206} set, odd bits clear.
- `mul_ack` delayed 3 cycles per request → req and operands are held stable while waiting; latency is 6+4·3=18 cycles; result matches a software GF(2) multiply on 1000 random operand pairs.
- `out_ready` held low for 5 cycles after `out_valid` → `out_p` is stable, `in_ready` stays 0, and `in_valid` is not accepted.
- `rst` pulsed while in ISSUE at idx 2 → the next cycle shows IDLE, `mul_req`=0, `out_valid`=0. A new operation then completes correctly, and a spurious `mul_ack` with req low has no effect.
